psram_arbiter: RTL

Two-port arbiter placed in front of `ram_controller`. It shares the single PSRAM access path between two requesters, for example the Ethernet frame writer on port 0 and the UART/readback engine on port 1. The arbiter serialises single-word transactions with round-robin fairness and drives the controller's `mem`/`rw`/`address`/`data_in` handshake. It also guards every access with a ready-timeout watchdog.

---
 rtl/psram_arbiter_if.sv | 39 +++
 rtl/psram_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/psram_arbiter_if.sv
// Signal bundle between the two requesters, the PSRAM arbiter and the ram_controller.
// The arbiter connects through the slave modport; the environment drives it through the master modport.
interface psram_arbiter_if #(
  parameter int AW = 23,
  parameter int DW = 16
);
  logic          req0, req1;
  logic          rw0, rw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem;
  logic          rw;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic          initialized;
  logic          ready;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          owner;
  logic          timeout;

  modport slave (
    input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    input  initialized, ready, data_out,
    output ack0, ack1, rdata0, rdata1,
    output mem, rw, address, data_in,
    output busy, owner, timeout
  );

  modport master (
    output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
    output initialized, ready, data_out,
    input  ack0, ack1, rdata0, rdata1,
    input  mem, rw, address, data_in,
    input  busy, owner, timeout
  );
endinterface

// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller between two single-word requesters,
// with a per-access ready watchdog that aborts a stalled access and raises a sticky flag.
module psram_arbiter #(
  parameter int AW      = 23,
  parameter int DW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset,
  psram_arbiter_if.slave  bus
);
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {WAIT_INIT, IDLE, ACCESS, ACK} state_t;

  state_t          state_q, state_d;
  logic            mem_q, mem_d;
  logic            rw_q, rw_d;
  logic [AW-1:0]   address_q, address_d;
  logic [DW-1:0]   data_in_q, data_in_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            owner_q, owner_d;
  logic            timeout_q, timeout_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT_INIT;
      mem_q     <= 1'b0;
      rw_q      <= 1'b0;
      address_q <= '0;
      data_in_q <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      owner_q   <= 1'b1;
      timeout_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      rw_q      <= rw_d;
      address_q <= address_d;
      data_in_q <= data_in_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
      wd_q      <= wd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    rw_d      = rw_q;
    address_d = address_q;
    data_in_d = data_in_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    owner_d   = owner_q;
    timeout_d = timeout_q;
    wd_d      = wd_q;
    grant     = owner_q;
    case (state_q)
      WAIT_INIT: begin
        if (bus.initialized) state_d = IDLE;
      end
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Under contention the port that did not own the last transaction wins.
          grant     = (bus.req0 && bus.req1) ? ~owner_q : bus.req1;
          owner_d   = grant;
          rw_d      = grant ? bus.rw1    : bus.rw0;
          address_d = grant ? bus.addr1  : bus.addr0;
          data_in_d = grant ? bus.wdata1 : bus.wdata0;
          mem_d     = 1'b1;
          wd_d      = '0;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.ready) begin
          if (rw_q) begin
            if (owner_q) rdata1_d = bus.data_out;
            else         rdata0_d = bus.data_out;
          end
          mem_d   = 1'b0;
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          state_d = ACK;
        end else if (wd_q == WD_LAST) begin
          // Abort completes the handshake so the requester is never left hanging.
          mem_d     = 1'b0;
          timeout_d = 1'b1;
          ack0_d    = ~owner_q;
          ack1_d    = owner_q;
          state_d   = ACK;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: state_d = WAIT_INIT;
    endcase
  end

  assign bus.mem     = mem_q;
  assign bus.rw      = rw_q;
  assign bus.address = address_q;
  assign bus.data_in = data_in_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.owner   = owner_q;
  assign bus.timeout = timeout_q;
  assign bus.busy    = (state_q == ACCESS) || (state_q == ACK);
endmodule
